// File: rtl/blockram_hs.sv
// rtl/blockram_hs.sv - Block RAM with valid/ready request, registered back-pressurable response, alias window and clear.
module blockram_hs #(
    parameter int DATA_W         = 32,
    parameter int BE_W           = DATA_W / 8,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 256,
    parameter int ALIAS_LSB      = 26,
    parameter int ALIAS_BYTES    = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIAS_MASK = ADDR_W'(ALIAS_BYTES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               clear_we;
    logic               accept;

    logic               aliased;
    logic [ADDR_W-1:0]  eff_addr;
    logic [ADDR_W-1:0]  word_addr;
    logic [IDX_W-1:0]   idx;
    logic               oor;
    logic [DATA_W-1:0]  rd_word;

    logic [DATA_W-1:0]  mem [DEPTH];

    always_comb begin
        aliased   = |req_addr[ADDR_W-1:ALIAS_LSB];
        eff_addr  = aliased ? (req_addr & ALIAS_MASK) : req_addr;
        word_addr = eff_addr >> OFF_W;
        idx       = word_addr[IDX_W-1:0];
        // Aliased accesses always land inside the window, so only direct ones can miss.
        oor       = !aliased && (|word_addr[ADDR_W-1:IDX_W]);
        rd_word   = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        req_ready = rst_n && (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
        init_done = (state_q == ST_RUN);
        clear_we  = rst_n && (state_q == ST_INIT);
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt_q] <= '0;
        end else if (accept && req_we && !oor) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = oor ? '0 : rd_word;
            rsp_err_d   = oor;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
